// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage ALU pipeline over a small register file.
// An operation is issued (operands read, ALU evaluated) at the accept edge,
// held in stage 2 for one cycle, and written back at the following edge.
// A stage-2 result that is about to be written back is forwarded to the
// issuing operation so back-to-back dependent operations see fresh values.
module datapath_pipe #(
    parameter int WIDTH = 32,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_control,
    input  logic [AW-1:0]    addr1,
    input  logic [AW-1:0]    addr2,
    input  logic [AW-1:0]    addr3,
    input  logic             wr,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_result,
    output logic             overflow,
    output logic             carry,
    output logic             err,
    output logic [15:0]      retired,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int NREG = 2 ** AW;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;

    // Packed ALU outcome: {err, overflow, carry, result}.
    localparam int ALU_W = WIDTH + 3;

    logic [WIDTH-1:0] regs [NREG];

    // Stage-2 (retiring) register
    logic             vld_p1;
    logic [WIDTH-1:0] res_p1;
    logic             ovf_p1;
    logic             carry_p1;
    logic             err_p1;
    logic             wr_p1;
    logic [AW-1:0]    addr3_p1;

    // Issue-stage combinational values
    logic             accept;
    logic             fwd_ok;
    logic             wb_en;
    logic [WIDTH-1:0] opa_p0;
    logic [WIDTH-1:0] opb_p0;
    logic [ALU_W-1:0] alu_p0;

    // ALU evaluation; subtraction uses A + ~B + 1 so carry means "no borrow".
    function automatic logic [ALU_W-1:0] alu_eval(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [WIDTH:0]          sum;
        logic [WIDTH-1:0]        r;
        logic                    ov;
        logic                    c;
        logic                    e;
        sa  = $signed(a);
        sb  = $signed(b);
        sum = '0;
        r   = '0;
        ov  = 1'b0;
        c   = 1'b0;
        e   = 1'b0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                ov  = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                ov  = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: r = a & b;
            OP_XOR: r = a ^ b;
            OP_SLT: r = {{(WIDTH-1){1'b0}}, (sa < sb)};
            default: e = 1'b1;
        endcase
        return {e, ov, c, r};
    endfunction

    assign in_ready = !ld_en && !rst;
    assign accept   = in_valid && in_ready;
    assign wb_en    = vld_p1 && wr_p1 && !err_p1;
    assign fwd_ok   = wb_en;

    // Issue stage: operand select with forwarding from stage 2, then ALU
    always_comb begin
        opa_p0 = regs[addr1];
        opb_p0 = regs[addr2];
        if (fwd_ok && (addr3_p1 == addr1)) begin
            opa_p0 = res_p1;
        end
        if (fwd_ok && (addr3_p1 == addr2)) begin
            opb_p0 = res_p1;
        end
        alu_p0 = alu_eval(alu_control, opa_p0, opb_p0);
    end

    // ---- stage boundary: issue -> stage 2 ----
    // Capture the issued operation; fields hold when nothing is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            res_p1   <= '0;
            ovf_p1   <= 1'b0;
            carry_p1 <= 1'b0;
            err_p1   <= 1'b0;
            wr_p1    <= 1'b0;
            addr3_p1 <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                err_p1   <= alu_p0[WIDTH+2];
                ovf_p1   <= alu_p0[WIDTH+1];
                carry_p1 <= alu_p0[WIDTH];
                res_p1   <= alu_p0[WIDTH-1:0];
                wr_p1    <= wr;
                addr3_p1 <= addr3;
            end
        end
    end

    // ---- stage boundary: stage 2 -> register file ----
    // Writeback then direct load; the later assignment lets the load win
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wb_en) begin
                regs[addr3_p1] <= res_p1;
            end
            if (ld_en) begin
                regs[ld_addr] <= ld_data;
            end
        end
    end

    // Count every retirement pulse, illegal opcodes included; wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= '0;
        end else if (vld_p1) begin
            retired <= retired + 16'd1;
        end
    end

    assign out_valid  = vld_p1;
    assign alu_result = res_p1;
    assign overflow   = ovf_p1;
    assign carry      = carry_p1;
    assign err        = err_p1;
    assign dbg_data   = regs[dbg_addr];

endmodule

// File: doc/datapath_pipe.md
DATAPATH_PIPE -- requirements
Module: datapath_pipe

Interface
REQ-001 Parameter WIDTH, default 32, datapath and register width (WIDTH >= 2).
REQ-002 Parameter AW, default 2, register address width; register file holds 2**AW registers.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  operation request.
REQ-007 in_ready  out  1  operation accepted this edge when in_valid&&in_ready.
REQ-008 alu_control  in  3  opcode: 000 add, 001 sub, 010 and, 011 xor, 100 slt, 101-111 illegal.
REQ-009 addr1, addr2  in  AW  source register addresses (A, B).
REQ-010 addr3  in  AW  destination register address.
REQ-011 wr  in  1  write result to addr3 on retirement.
REQ-012 ld_en  in  1  direct register load request.
REQ-013 ld_addr  in  AW; ld_data  in  WIDTH  load target and value.
REQ-014 out_valid  out  1  one-cycle pulse per retired operation.
REQ-015 alu_result  out  WIDTH; overflow, carry, err  out  1 each; all valid while out_valid=1.
REQ-016 retired  out  16  count of retired operations, including illegal ones.
REQ-017 dbg_addr  in  AW; dbg_data  out  WIDTH  combinational read of register array, no forwarding.

Function
REQ-018 in_ready SHALL equal !ld_en && !rst; load takes priority over issue.
REQ-019 Load: ld_en=1 SHALL write ld_data to register ld_addr at the edge.
REQ-020 Issue stage: on accept edge E0, the ALU result, flags, addr3, wr, and err SHALL be captured into the stage-2 register; out_valid=1 during the cycle after E0.
REQ-021 Writeback: at edge E1, if stage-2 valid && wr && !err, stage-2 result SHALL be written to the addr3 register.
REQ-022 Latency SHALL be 1 cycle to out_valid and 2 edges to register update; throughput SHALL be 1 operation per cycle.
REQ-023 Forwarding: if stage-2 is valid with wr=1, err=0, and addr3 equals addr1 or addr2 of the issuing op, that operand SHALL come from the stage-2 result; otherwise it SHALL come from the register array.
REQ-024 Simultaneous load and stage-2 writeback to the same address: the load value SHALL win.
REQ-025 add: result = A+B mod 2**WIDTH; carry = carry out of MSB; overflow = signed overflow.
REQ-026 sub: result = A-B mod 2**WIDTH, computed as A+~B+1; carry = carry out (1 when A>=B unsigned); overflow = signed overflow.
REQ-027 and/xor: bitwise result; carry=0, overflow=0.
REQ-028 slt: result = 1 zero-extended if A<B signed, else 0; carry=0, overflow=0.
REQ-029 Illegal opcode: result=0, flags=0, err=1, no register write, not a forwarding source; out_valid still pulses.
REQ-030 retired SHALL increment by 1 per out_valid pulse and wrap 0xFFFF->0x0000.
REQ-031 Outputs alu_result/overflow/carry/err SHALL hold their last values when out_valid=0.

Reset
REQ-032 rst=1 at an edge SHALL clear all registers, stage-2 valid, out_valid, alu_result, overflow, carry, err, and retired to 0.
REQ-033 Reset mid-operation SHALL discard any pending writeback, and no register write SHALL occur at that edge (load included).
REQ-034 Requests presented while rst=1 SHALL not be accepted.

Verification (WIDTH=32, AW=2)
REQ-035 Load R1=5, R2=7, R3=0xF; then back-to-back ops R0<-R1+R2, R1<-R0 AND R3, R3<-R2 XOR R1, R2<-R1-R3 -> results 0xC, 0xC, 0xB, 0x1; sub gives carry=1; final R0..R3 = 0xC, 0xC, 0x1, 0xB (forwarding exercised).
REQ-036 R1=0x7FFFFFFF, R2=1, add -> 0x80000000, overflow=1, carry=0; R1=0xFFFFFFFF+R2=1 -> 0x0, carry=1, overflow=0.
REQ-037 R1=0, R2=1, sub -> 0xFFFFFFFF, carry=0; slt R1=0xFFFFFFFF, R2=1 -> 0x1; slt swapped -> 0x0.
REQ-038 Opcode 110 with wr=1 targeting R0=0xC -> out_valid pulse, err=1, result 0, R0 stays 0xC; retired still increments.
REQ-039 ld_en=1 together with in_valid -> in_ready=0, op not accepted; load and stage-2 writeback to R2 in the same edge -> R2 holds ld_data.
REQ-040 rst asserted in the cycle after accepting a wr=1 op to R3 -> R3=0, out_valid=0, retired=0; 65536 retirements -> retired wraps to 0.
